// File: rtl/ts_pkg.sv
// Shared record layout, header helpers and SPI shifter states for the
// multi-channel timestamper.
package ts_pkg;

    localparam int HDR_W      = 8;
    localparam int HDR_VALID  = 7;
    localparam int HDR_LOST   = 6;
    localparam int HDR_CH_MSB = 3;
    localparam int HDR_CH_LSB = 0;

    typedef enum logic {
        SPI_IDLE  = 1'b0,
        SPI_SHIFT = 1'b1
    } spi_state_t;

    function automatic int record_w(input int cnt_w);
        return HDR_W + cnt_w;
    endfunction

    function automatic logic [HDR_W-1:0] make_hdr(input logic lost, input logic [3:0] ch);
        logic [HDR_W-1:0] hdr;
        hdr                        = '0;
        hdr[HDR_VALID]             = 1'b1;
        hdr[HDR_LOST]              = lost;
        hdr[HDR_CH_MSB:HDR_CH_LSB] = ch;
        return hdr;
    endfunction

endpackage

// File: rtl/ts_sync_fifo.sv
// Single-clock record queue with head peek. A push while full and a pop while
// empty are dropped; push and pop in the same cycle are both honoured.
module ts_sync_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         peek_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full      = (cnt == (AW+1)'(DEPTH));
    assign empty     = (cnt == '0);
    assign count     = cnt;
    assign peek_data = mem[rd_ptr];
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/multi_channel_timestamper.sv
// Free-running timebase with per-channel edge capture into a record queue,
// drained by the host over a mode-0 SPI slave.
//
// state     | meaning
// SPI_IDLE  | chip enable high (synced); SDO held 0
// SPI_SHIFT | record loaded on CE_N fall; SCLK falls shift, last rise pops
module multi_channel_timestamper
    import ts_pkg::*;
#(
    parameter int CNT_WIDTH   = 32,
    parameter int NUM_CH      = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CNT_CLR,
    input  logic [NUM_CH-1:0] CAPT,
    input  logic              SCLK,
    input  logic              CE_N,
    output logic              SDO,
    output logic              INT
);

    localparam int RECORD_W = record_w(CNT_WIDTH);
    localparam int BIT_W    = $clog2(RECORD_W + 1);
    localparam int FCNT_W   = $clog2(FIFO_DEPTH) + 1;

    logic [CNT_WIDTH-1:0]   count;
    logic [NUM_CH-1:0]      capt_sync [SYNC_STAGES];
    logic [NUM_CH-1:0]      capt_prev;
    logic [NUM_CH-1:0]      detect;
    logic [NUM_CH-1:0]      pend;
    logic [NUM_CH-1:0]      lost;
    logic [CNT_WIDTH-1:0]   ts [NUM_CH];
    logic [NUM_CH-1:0]      grant;
    logic [NUM_CH-1:0]      taken;
    logic [RECORD_W-1:0]    push_rec;
    logic                   push_req;
    logic                   push;

    logic [RECORD_W-1:0]    head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FCNT_W-1:0]      fifo_count;
    logic                   pop;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ce_sync;
    logic                   sclk_prev;
    logic                   ce_prev;
    logic                   sclk_s;
    logic                   ce_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   ce_fall;
    logic                   ce_rise;

    spi_state_t             spi_state;
    logic [RECORD_W-1:0]    shift_reg;
    logic [BIT_W-1:0]       bit_cnt;
    logic                   loaded_valid;
    logic                   int_r;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= '0;
        end else if (CNT_CLR) begin
            count <= '0;
        end else begin
            count <= count + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int s = 0; s < SYNC_STAGES; s++) capt_sync[s] <= '0;
            capt_prev <= '0;
            sclk_sync <= '0;
            ce_sync   <= '0;
            sclk_prev <= 1'b0;
            ce_prev   <= 1'b0;
        end else begin
            capt_sync[0] <= CAPT;
            for (int s = 1; s < SYNC_STAGES; s++) capt_sync[s] <= capt_sync[s-1];
            capt_prev <= capt_sync[SYNC_STAGES-1];
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            ce_sync   <= {ce_sync[SYNC_STAGES-2:0], CE_N};
            sclk_prev <= sclk_s;
            ce_prev   <= ce_s;
        end
    end

    assign detect    = capt_sync[SYNC_STAGES-1] & ~capt_prev;
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ce_s      = ce_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign ce_fall   = ~ce_s & ce_prev;
    assign ce_rise   = ce_s & ~ce_prev;

    // Fixed priority: the lowest-numbered pending channel wins the push slot.
    always_comb begin
        grant    = '0;
        push_rec = '0;
        push_req = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pend[i] && !push_req) begin
                grant[i] = 1'b1;
                push_req = 1'b1;
                push_rec = {make_hdr(lost[i], 4'(i)), ts[i]};
            end
        end
    end

    assign push  = push_req & ~fifo_full;
    assign taken = grant & {NUM_CH{push}};

    // An edge arriving while the slot is still occupied keeps the older
    // timestamp; one arriving as the slot drains replaces it cleanly.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend <= '0;
            lost <= '0;
            for (int i = 0; i < NUM_CH; i++) ts[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (detect[i]) begin
                    if (pend[i] && !taken[i]) begin
                        lost[i] <= 1'b1;
                    end else begin
                        pend[i] <= 1'b1;
                        lost[i] <= 1'b0;
                        ts[i]   <= count;
                    end
                end else if (taken[i]) begin
                    pend[i] <= 1'b0;
                    lost[i] <= 1'b0;
                end
            end
        end
    end

    ts_sync_fifo #(
        .WIDTH (RECORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST_N),
        .push      (push),
        .push_data (push_rec),
        .pop       (pop),
        .peek_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // bit_cnt saturates at RECORD_W, so the pop fires at most once per load.
    assign pop = (spi_state == SPI_SHIFT) & sclk_rise & loaded_valid
                 & (bit_cnt == BIT_W'(RECORD_W - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            spi_state    <= SPI_IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            loaded_valid <= 1'b0;
        end else begin
            case (spi_state)
                SPI_IDLE: begin
                    if (ce_fall) begin
                        spi_state    <= SPI_SHIFT;
                        shift_reg    <= fifo_empty ? '0 : head;
                        loaded_valid <= ~fifo_empty;
                        bit_cnt      <= '0;
                    end
                end
                SPI_SHIFT: begin
                    if (ce_rise) begin
                        spi_state    <= SPI_IDLE;
                        loaded_valid <= 1'b0;
                    end else begin
                        if (sclk_rise && bit_cnt != BIT_W'(RECORD_W))
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        if (sclk_fall)
                            shift_reg <= {shift_reg[RECORD_W-2:0], 1'b0};
                    end
                end
                default: spi_state <= SPI_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) int_r <= 1'b0;
        else        int_r <= (fifo_count != '0);
    end

    assign SDO = (spi_state == SPI_SHIFT) & shift_reg[RECORD_W-1];
    assign INT = int_r;

endmodule

// File: tb/tb_multi_channel_timestamper.sv
// Scoreboard bench: a transaction-level queue model predicts every SPI read;
// a separate monitor compares observed reads against the predictions.
module tb_multi_channel_timestamper;

    localparam int CNT_W = 32;
    localparam int NCH   = 4;
    localparam int DEPTH = 8;
    localparam int SS    = 2;
    localparam int RW    = CNT_W + 8;

    typedef struct {
        logic [RW-1:0] rec;
        int            nbits;
    } xfer_t;

    logic           clk;
    logic           rst_n;
    logic           cnt_clr;
    logic [NCH-1:0] capt;
    logic           sclk;
    logic           ce_n;
    logic           sdo;
    logic           int_o;

    int total = 0;
    int bad   = 0;

    xfer_t exp_q [$];
    xfer_t obs_q [$];

    logic [RW-1:0]    m_fifo [$];
    bit               m_pend [NCH];
    bit               m_lost [NCH];
    logic [CNT_W-1:0] m_ts   [NCH];
    logic [CNT_W-1:0] m_cnt;

    multi_channel_timestamper #(
        .CNT_WIDTH   (CNT_W),
        .NUM_CH      (NCH),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SS)
    ) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .CNT_CLR (cnt_clr),
        .CAPT    (capt),
        .SCLK    (sclk),
        .CE_N    (ce_n),
        .SDO     (sdo),
        .INT     (int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference timebase: value the counter holds between edges.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       m_cnt <= '0;
        else if (cnt_clr) m_cnt <= '0;
        else              m_cnt <= m_cnt + 1;
    end

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void m_clear();
        m_fifo.delete();
        for (int i = 0; i < NCH; i++) begin
            m_pend[i] = 0;
            m_lost[i] = 0;
            m_ts[i]   = '0;
        end
    endfunction

    function automatic void m_capture(input int ch, input logic [CNT_W-1:0] t);
        if (m_pend[ch]) begin
            m_lost[ch] = 1;
        end else begin
            m_pend[ch] = 1;
            m_lost[ch] = 0;
            m_ts[ch]   = t;
        end
    endfunction

    function automatic void m_settle();
        int k;
        while (m_fifo.size() < DEPTH) begin
            k = -1;
            for (int i = 0; i < NCH; i++) if (m_pend[i] && k < 0) k = i;
            if (k < 0) break;
            m_fifo.push_back({1'b1, m_lost[k], 2'b00, 4'(k), m_ts[k]});
            m_pend[k] = 0;
            m_lost[k] = 0;
        end
    endfunction

    task automatic capture(input logic [NCH-1:0] mask, input int hi, input int lo, input longint fixed_ts);
        logic [CNT_W-1:0] t;
        t = (fixed_ts >= 0) ? CNT_W'(fixed_ts) : m_cnt + CNT_W'(SS);
        for (int i = 0; i < NCH; i++) if (mask[i]) m_capture(i, t);
        m_settle();
        capt = mask;
        repeat (hi) @(negedge clk);
        capt = '0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic spi_xfer(input int nbits, output logic [RW-1:0] rx);
        rx   = '0;
        ce_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            rx   = {rx[RW-2:0], sdo};
            sclk = 1'b1;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
            repeat (8) @(negedge clk);
        end
        if (nbits < RW) rx = rx << (RW - nbits);
        ce_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_read(input int nbits);
        xfer_t         e;
        xfer_t         o;
        logic [RW-1:0] rx;
        logic [RW-1:0] dummy;
        e.nbits = nbits;
        e.rec   = (m_fifo.size() != 0) ? m_fifo[0] : '0;
        if (nbits >= RW && m_fifo.size() != 0) begin
            dummy = m_fifo.pop_front();
            m_settle();
        end
        exp_q.push_back(e);
        spi_xfer(nbits, rx);
        o.rec   = rx;
        o.nbits = nbits;
        obs_q.push_back(o);
    endtask

    initial begin : monitor
        xfer_t         o;
        xfer_t         e;
        logic [RW-1:0] msk;
        forever begin
            @(negedge clk);
            while (obs_q.size() != 0) begin
                o = obs_q.pop_front();
                if (exp_q.size() == 0) begin
                    check("unexpected_read", o.rec, '1);
                end else begin
                    e   = exp_q.pop_front();
                    msk = '1;
                    msk = msk << (RW - o.nbits);
                    check("spi_record", o.rec & msk, e.rec & msk);
                end
            end
        end
    end

    initial begin
        logic [NCH-1:0] mask;
        int             act;
        rst_n   = 1'b0;
        cnt_clr = 1'b0;
        capt    = '0;
        sclk    = 1'b0;
        ce_n    = 1'b1;
        m_clear();
        repeat (4) @(negedge clk);
        check("reset_int", RW'(int_o), '0);
        check("reset_sdo", RW'(sdo), '0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // 1: timebase clear, 100 cycles, single capture on ch0
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        repeat (100) @(negedge clk);
        capture(4'b0001, 5, 5, 100 + SS);
        check("t1_int_high", RW'(int_o), RW'(1));
        do_read(RW);
        check("t1_int_low", RW'(int_o), '0);

        // 2: all channels in the same cycle
        capture(4'b1111, 5, 10, -1);
        for (int r = 0; r < 4; r++) begin
            do_read(RW);
            check("t2_int", RW'(int_o), (r < 3) ? RW'(1) : RW'(0));
        end

        // 3: overflow on ch1, no reads until ten edges are in
        for (int e = 0; e < DEPTH + 2; e++) capture(4'b0010, 5, 5, -1);
        repeat (5) @(negedge clk);
        check("t3_int_full", RW'(int_o), RW'(1));
        for (int r = 0; r < DEPTH + 1; r++) do_read(RW);
        check("t3_int_drained", RW'(int_o), '0);

        // 4: read while empty
        do_read(RW);
        check("t4_int_idle", RW'(int_o), '0);

        // 5: aborted read re-presents the same record
        capture(4'b0100, 5, 5, -1);
        capture(4'b1000, 5, 5, -1);
        do_read(12);
        do_read(RW);
        do_read(RW);
        do_read(RW);

        // 6: reset in the middle of a transfer
        capture(4'b0111, 5, 10, -1);
        ce_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < 10; b++) begin
            sclk = 1'b1;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
            repeat (8) @(negedge clk);
        end
        rst_n = 1'b0;
        m_clear();
        #1;
        check("t6_int_in_reset", RW'(int_o), '0);
        check("t6_sdo_in_reset", RW'(sdo), '0);
        repeat (3) @(negedge clk);
        ce_n  = 1'b1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        capture(4'b0001, 5, 5, 20 + SS);
        do_read(RW);
        do_read(RW);

        // randomized mix of captures, full/partial reads and timebase clears
        for (int it = 0; it < 25; it++) begin
            act = $urandom_range(0, 5);
            if (act <= 2) begin
                mask = NCH'($urandom_range(1, (1 << NCH) - 1));
                capture(mask, $urandom_range(4, 8), $urandom_range(6, 10), -1);
            end else if (act == 3) begin
                do_read(RW);
            end else if (act == 4) begin
                do_read($urandom_range(1, RW - 1));
            end else begin
                cnt_clr = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                cnt_clr = 1'b0;
                @(negedge clk);
            end
        end
        while (m_fifo.size() != 0) do_read(RW);
        check("rand_int_drained", RW'(int_o), '0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", RW'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
